// File: rtl/layer_seq_ctrl.sv
// layer_seq_ctrl: raster ROM read sequencer with position-derived S2/C3/S4/C5 consume enables.
// Optional LAYER_SEQ_CONTINUOUS_EN: frames stream back-to-back without returning to IDLE.
`default_nettype none

module layer_seq_ctrl #(
  parameter int COLS      = 32,
  parameter int ROWS      = 32,
  parameter int K         = 5,
  parameter int POOL_LOG2 = 1,
  parameter int LAT       = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start_i,
  input  logic                           hold_i,
  output logic                           rd_o,
  output logic [$clog2(ROWS*COLS)-1:0]   rd_addr_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           S2_en_o,
  output logic                           C3_en_o,
  output logic                           S4_en_o,
  output logic                           C5_en_o
);

  localparam int AW = $clog2(ROWS*COLS);
  localparam int RW = $clog2(ROWS+1);
  localparam int PM = (1 << POOL_LOG2) - 1;
  localparam int H1 = ROWS - K + 1;
  localparam int H2 = H1 >>> POOL_LOG2;
  localparam int H3 = H2 - K + 1;
  localparam int H4 = H3 >>> POOL_LOG2;

  if ((COLS != ROWS) || (K < 1) || (LAT < 1) || (H1 < 1) || (H3 < 1) || (H4 < 1) ||
      ((H1 & PM) != 0) || ((H3 & PM) != 0)) begin : g_param_check
    $error("layer_seq_ctrl: illegal ROWS/COLS/K/POOL_LOG2/LAT combination");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  // Tag bit positions in the delay line
  localparam int T_S2 = 0, T_C3 = 1, T_S4 = 2, T_C5 = 3, T_LAST = 4;

  state_t          state_q, state_d;
  logic [RW-1:0]   r_q, r_d, c_q, c_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [4:0]      dly_q [LAT];
  logic [4:0]      tag_in;
  logic            rd;
  logic            last;
  int              u, v, pc, qc;
  logic            s2f, c3f, s4f, c5f;

  // Position flags; negative grid coordinates are masked by the s2f/s4f guards.
  always_comb begin
    u    = int'(r_q) - (K - 1);
    v    = int'(c_q) - (K - 1);
    pc   = (u >>> POOL_LOG2) - (K - 1);
    qc   = (v >>> POOL_LOG2) - (K - 1);
    s2f  = (u >= 0) && (v >= 0);
    c3f  = s2f && ((u & PM) == PM) && ((v & PM) == PM);
    s4f  = c3f && (pc >= 0) && (qc >= 0);
    c5f  = s4f && ((pc & PM) == PM) && ((qc & PM) == PM);
    last = (r_q == RW'(ROWS - 1)) && (c_q == RW'(COLS - 1));
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    addr_d  = addr_q;
    rd      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          r_d     = '0;
          c_d     = '0;
          addr_d  = '0;
        end
      end
      RUN: begin
        rd = ~hold_i;
        if (rd) begin
          if (last) begin
            r_d    = '0;
            c_d    = '0;
            addr_d = '0;
`ifdef LAYER_SEQ_CONTINUOUS_EN
            state_d = RUN;
`else
            state_d = DRAIN;
`endif
          end else if (c_q == RW'(COLS - 1)) begin
            c_d    = '0;
            r_d    = r_q + 1'b1;
            addr_d = addr_q + 1'b1;
          end else begin
            c_d    = c_q + 1'b1;
            addr_d = addr_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (dly_q[LAT-1][T_LAST]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Hold bubbles enter the delay line as empty tags.
  assign tag_in = rd ? {last, c5f, s4f, c3f, s2f} : 5'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      c_q     <= '0;
      addr_q  <= '0;
      for (int i = 0; i < LAT; i++) dly_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      c_q      <= c_d;
      addr_q   <= addr_d;
      dly_q[0] <= tag_in;
      for (int i = 1; i < LAT; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  assign rd_o      = rd;
  assign rd_addr_o = addr_q;
  assign busy_o    = (state_q != IDLE);
  assign done_o    = dly_q[LAT-1][T_LAST];
  assign S2_en_o   = dly_q[LAT-1][T_S2];
  assign C3_en_o   = dly_q[LAT-1][T_C3];
  assign S4_en_o   = dly_q[LAT-1][T_S4];
  assign C5_en_o   = dly_q[LAT-1][T_C5];

endmodule

`default_nettype wire

// File: tb/tb_layer_seq_ctrl.sv
// tb_layer_seq_ctrl: randomized-hold frame runs checked against a raster/queue reference model.
`default_nettype none

module tb_layer_seq_ctrl;
`ifdef LAYER_SEQ_CONTINUOUS_EN
  localparam int ROWS = 18, COLS = 18, K = 3;
`else
  localparam int ROWS = 32, COLS = 32, K = 5;
`endif
  localparam int PL = 1, LAT = 2, P = 1 << PL, N = ROWS * COLS, AW = $clog2(N);
  localparam int H1 = ROWS - K + 1, H2 = H1 / P, H3 = H2 - K + 1, H4 = H3 / P;

  logic clk = 1'b0, rst_n = 1'b0, start_i = 1'b0, hold_i = 1'b0;
  logic rd_o, busy_o, done_o, S2_en_o, C3_en_o, S4_en_o, C5_en_o;
  logic [AW-1:0] rd_addr_o;
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  layer_seq_ctrl #(.COLS(COLS), .ROWS(ROWS), .K(K), .POOL_LOG2(PL), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .hold_i(hold_i),
    .rd_o(rd_o), .rd_addr_o(rd_addr_o), .busy_o(busy_o), .done_o(done_o),
    .S2_en_o(S2_en_o), .C3_en_o(C3_en_o), .S4_en_o(S4_en_o), .C5_en_o(C5_en_o)
  );

  // Expected {last,C5,S4,C3,S2} for a pixel, straight from the grid definitions.
  function automatic logic [4:0] exp_tag(input int a);
    int r, c, u, v;
    logic [4:0] t;
    r = a / COLS; c = a % COLS;
    u = r - (K - 1); v = c - (K - 1);
    t = '0;
    t[0] = (u >= 0) && (v >= 0);
    t[1] = t[0] && (u % P == P - 1) && (v % P == P - 1);
    t[2] = t[1] && (u / P >= K - 1) && (v / P >= K - 1);
    t[3] = t[2] && ((u / P - (K - 1)) % P == P - 1) && ((v / P - (K - 1)) % P == P - 1);
    t[4] = (a == N - 1);
    return t;
  endfunction

  // mode: 0 no hold, 1 hold every other cycle, 2 random hold. Entered and left near a negedge.
  task automatic run_frame(input int mode, input int frames, input int abort_at, input bit poke);
    logic [4:0] pipe[$];
    logic [4:0] front;
    int idx = 0, cyc = 0, dones = 0, last_done = -1, first_rd = -1, last_rd = -1;
    int cnt[4];
    bit exp_rd;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    for (int i = 0; i < LAT; i++) pipe.push_back(5'b0);
    start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    while (dones < frames && cyc < 6 * N + 100) begin
      hold_i = (mode == 0) ? 1'b0 : (mode == 1) ? cyc[0] : ($urandom_range(0, 2) == 0);
      if (poke) start_i = (cyc == N / 3) || pipe[0][4];
      if (idx == abort_at) begin
        hold_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({rd_o, busy_o, done_o, S2_en_o, C3_en_o, S4_en_o, C5_en_o} !== 7'b0 || rd_addr_o !== '0) begin
          n_err++;
          $display("FAIL abort_outputs got=%b addr=%0d exp=0", {rd_o, busy_o, done_o, S2_en_o, C3_en_o, S4_en_o, C5_en_o}, rd_addr_o);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < LAT + 3; i++) begin
          @(negedge clk);
          n_vec++;
          if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL abort_no_done done=%b busy=%b exp=0/0", done_o, busy_o);
          end
        end
        return;
      end
      @(negedge clk);
`ifdef LAYER_SEQ_CONTINUOUS_EN
      exp_rd = !hold_i;
`else
      exp_rd = !hold_i && (idx < N);
`endif
      front = pipe.pop_front();
      n_vec++;
      if (rd_o !== exp_rd) begin
        n_err++; $display("FAIL rd cyc=%0d got=%b exp=%b", cyc, rd_o, exp_rd);
      end
      if (exp_rd) begin
        n_vec++;
        if (rd_addr_o !== AW'(idx % N)) begin
          n_err++; $display("FAIL rd_addr cyc=%0d got=%0d exp=%0d", cyc, rd_addr_o, idx % N);
        end
      end
      n_vec++;
      if ({done_o, C5_en_o, S4_en_o, C3_en_o, S2_en_o} !== front) begin
        n_err++;
        $display("FAIL enables cyc=%0d got=%b exp=%b", cyc, {done_o, C5_en_o, S4_en_o, C3_en_o, S2_en_o}, front);
      end
      n_vec++;
      if (busy_o !== 1'b1) begin
        n_err++; $display("FAIL busy_run cyc=%0d got=%b exp=1", cyc, busy_o);
      end
      if (rd_o === 1'b1) begin
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc;
      end
      if (exp_rd) begin
        pipe.push_back(exp_tag(idx % N));
        idx++;
      end else pipe.push_back(5'b0);
      cnt[0] += int'(S2_en_o); cnt[1] += int'(C3_en_o);
      cnt[2] += int'(S4_en_o); cnt[3] += int'(C5_en_o);
      if (front[4]) begin
        dones++;
        n_vec++;
        if (cnt[0] != H1 * H1 || cnt[1] != H2 * H2 || cnt[2] != H3 * H3 || cnt[3] != H4 * H4) begin
          n_err++;
          $display("FAIL frame_counts got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d",
                   cnt[0], cnt[1], cnt[2], cnt[3], H1 * H1, H2 * H2, H3 * H3, H4 * H4);
        end
        if (last_done >= 0 && mode == 0) begin
          n_vec++;
          if (cyc - last_done != N) begin
            n_err++; $display("FAIL done_spacing got=%0d exp=%0d", cyc - last_done, N);
          end
        end
        last_done = cyc;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
      end
      cyc++;
      @(posedge clk); #1 start_i = 1'b0;
    end
    n_vec++;
    if (dones < frames) begin
      n_err++; $display("FAIL timeout dones got=%0d exp=%0d", dones, frames);
    end
    if (mode == 1) begin
      n_vec++;
      if (last_rd - first_rd + 1 < 2 * N - 2 || last_rd - first_rd + 1 > 2 * N) begin
        n_err++; $display("FAIL hold_frame_len got=%0d exp=%0d", last_rd - first_rd + 1, 2 * N - 1);
      end
    end
    hold_i = 1'b0;
`ifndef LAYER_SEQ_CONTINUOUS_EN
    @(negedge clk);
    n_vec++;
    if (busy_o !== 1'b0 || rd_o !== 1'b0 || done_o !== 1'b0) begin
      n_err++; $display("FAIL post_done busy=%b rd=%b done=%b exp=0/0/0", busy_o, rd_o, done_o);
    end
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_i = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_vec++;
      if ({rd_o, busy_o, done_o, S2_en_o, C3_en_o, S4_en_o, C5_en_o} !== 7'b0 || rd_addr_o !== '0) begin
        n_err++; $display("FAIL reset_outputs got=%b addr=%0d exp=0", {rd_o, busy_o, done_o, S2_en_o, C3_en_o, S4_en_o, C5_en_o}, rd_addr_o);
      end
    end
    start_i = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (busy_o !== 1'b0 || rd_o !== 1'b0) begin
      n_err++; $display("FAIL idle_after_reset busy=%b rd=%b exp=0/0", busy_o, rd_o);
    end
  endtask

  task automatic test_full_frame();      run_frame(0, 1, -1, 1'b0); endtask
  task automatic test_hold_toggle();     run_frame(1, 1, -1, 1'b1); endtask
  task automatic test_back_to_back();    run_frame(2, 1, -1, 1'b0); endtask
  task automatic test_abort();           run_frame(0, 1, 500, 1'b0); endtask
  task automatic test_restart();         run_frame(0, 1, -1, 1'b0); endtask
  task automatic test_continuous();      run_frame(0, 2, -1, 1'b0); endtask

  initial begin
    test_reset();
`ifdef LAYER_SEQ_CONTINUOUS_EN
    test_continuous();
    rst_n = 1'b0;
    @(negedge clk);
`else
    test_full_frame();
    test_hold_toggle();
    test_back_to_back();
    test_abort();
    test_restart();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

`default_nettype wire
